pong_game_ctrl: RTL and testbench

Per-frame game-state scheduler for the pong display pipeline. Watches the display_signal counters, detects the start of vertical blanking, and sequences paddle update, ball move, and collision/score resolution, all within blanking. Publishes stable ball/paddle coordinates and scores to render, so render never sees a position change mid-frame.

---
 rtl/pong_game_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Per-frame pong game-state scheduler: on the start of vertical blanking it steps paddles,
// moves the ball and resolves hits/misses/scores so render only ever sees frame-stable values.
module pong_game_ctrl #(
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BALL_SIZE = 8,
  parameter int BALL_SPD  = 2,
  parameter int PAD_W     = 8,
  parameter int PAD_H     = 48,
  parameter int PAD_SPD   = 4,
  parameter int PAD_X_L   = 32,
  parameter int PAD_X_R   = 600
) (
  input  logic             pix_clk,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             btn_up_l,
  input  logic             btn_dn_l,
  input  logic             btn_up_r,
  input  logic             btn_dn_r,
  input  logic             serve,
  output logic [CORDW-1:0] ball_x,
  output logic [CORDW-1:0] ball_y,
  output logic [CORDW-1:0] pad_l_y,
  output logic [CORDW-1:0] pad_r_y,
  output logic [3:0]       score_l,
  output logic [3:0]       score_r,
  output logic             frame_tick,
  output logic             busy
);

  // One extra bit of headroom so sums like y+size+speed never wrap in comparisons.
  localparam int W = CORDW + 1;

  localparam logic [W-1:0] C_BX0   = W'((H_RES - BALL_SIZE) / 2);
  localparam logic [W-1:0] C_BY0   = W'((V_RES - BALL_SIZE) / 2);
  localparam logic [W-1:0] C_PY0   = W'((V_RES - PAD_H) / 2);
  localparam logic [W-1:0] C_HRES  = W'(H_RES);
  localparam logic [W-1:0] C_VRES  = W'(V_RES);
  localparam logic [W-1:0] C_BSZ   = W'(BALL_SIZE);
  localparam logic [W-1:0] C_BSPD  = W'(BALL_SPD);
  localparam logic [W-1:0] C_PW    = W'(PAD_W);
  localparam logic [W-1:0] C_PH    = W'(PAD_H);
  localparam logic [W-1:0] C_PSPD  = W'(PAD_SPD);
  localparam logic [W-1:0] C_PXL   = W'(PAD_X_L);
  localparam logic [W-1:0] C_PXR   = W'(PAD_X_R);

  typedef enum logic [2:0] {
    S_READY, S_WAIT, S_PADDLE, S_BALL, S_HIT, S_SCORE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_ball_x, r_ball_y, r_pad_l, r_pad_r;
  logic [W-1:0]   w_ball_x_nxt, w_ball_y_nxt, w_pad_l_nxt, w_pad_r_nxt;
  logic           r_dx_left, r_dy_up, r_play, r_tick;
  logic           w_dx_left_nxt, w_dy_up_nxt, w_play_nxt;
  logic [3:0]     r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;
  logic           w_hit_l, w_hit_r, w_miss_l, w_miss_r;

  function automatic logic [W-1:0] pad_step(input logic [W-1:0] y, input logic up, input logic dn);
    pad_step = y;
    if (up && !dn)
      pad_step = (y >= C_PSPD) ? y - C_PSPD : '0;
    else if (dn && !up)
      pad_step = (y + C_PH + C_PSPD <= C_VRES) ? y + C_PSPD : C_VRES - C_PH;
  endfunction

  assign w_hit_l  = r_dx_left && (r_ball_x <= C_PXL + C_PW) && (r_ball_x + C_BSZ > C_PXL) &&
                    (r_ball_y + C_BSZ > r_pad_l) && (r_ball_y < r_pad_l + C_PH);
  assign w_hit_r  = !r_dx_left && (r_ball_x + C_BSZ >= C_PXR) && (r_ball_x < C_PXR + C_PW) &&
                    (r_ball_y + C_BSZ > r_pad_r) && (r_ball_y < r_pad_r + C_PH);
  assign w_miss_l = r_dx_left && (r_ball_x < C_BSPD);
  assign w_miss_r = !r_dx_left && (r_ball_x + C_BSZ + C_BSPD > C_HRES);

  always_comb begin
    w_state_nxt   = r_state;
    w_ball_x_nxt  = r_ball_x;
    w_ball_y_nxt  = r_ball_y;
    w_pad_l_nxt   = r_pad_l;
    w_pad_r_nxt   = r_pad_r;
    w_dx_left_nxt = r_dx_left;
    w_dy_up_nxt   = r_dy_up;
    w_play_nxt    = r_play;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    case (r_state)
      S_READY: begin
        if (r_tick) begin
          w_state_nxt = S_PADDLE;
          w_play_nxt  = serve;
        end
      end
      S_WAIT: begin
        if (r_tick) w_state_nxt = S_PADDLE;
      end
      S_PADDLE: begin
        w_pad_l_nxt = pad_step(r_pad_l, btn_up_l, btn_dn_l);
        w_pad_r_nxt = pad_step(r_pad_r, btn_up_r, btn_dn_r);
        w_state_nxt = r_play ? S_BALL : S_READY;
      end
      S_BALL: begin
        // Left step clamps at 0; the miss check in HIT then sees x < speed.
        if (r_dx_left) w_ball_x_nxt = (r_ball_x >= C_BSPD) ? r_ball_x - C_BSPD : '0;
        else           w_ball_x_nxt = r_ball_x + C_BSPD;
        if (r_dy_up) begin
          if (r_ball_y < C_BSPD) begin
            w_ball_y_nxt = '0;
            w_dy_up_nxt  = 1'b0;
          end else begin
            w_ball_y_nxt = r_ball_y - C_BSPD;
          end
        end else begin
          if (r_ball_y + C_BSZ + C_BSPD > C_VRES) begin
            w_ball_y_nxt = C_VRES - C_BSZ;
            w_dy_up_nxt  = 1'b1;
          end else begin
            w_ball_y_nxt = r_ball_y + C_BSPD;
          end
        end
        w_state_nxt = S_HIT;
      end
      S_HIT: begin
        w_state_nxt = S_WAIT;
        if (w_hit_l) begin
          w_ball_x_nxt  = C_PXL + C_PW;
          w_dx_left_nxt = 1'b0;
        end else if (w_hit_r) begin
          w_ball_x_nxt  = C_PXR - C_BSZ;
          w_dx_left_nxt = 1'b1;
        end else if (w_miss_l || w_miss_r) begin
          w_state_nxt = S_SCORE;
        end
      end
      S_SCORE: begin
        // dx is unchanged since HIT, so it still tells which side missed.
        if (r_dx_left) begin
          w_score_r_nxt = (r_score_r == 4'd9) ? 4'd9 : r_score_r + 4'd1;
          w_dx_left_nxt = 1'b0;
        end else begin
          w_score_l_nxt = (r_score_l == 4'd9) ? 4'd9 : r_score_l + 4'd1;
          w_dx_left_nxt = 1'b1;
        end
        w_ball_x_nxt = C_BX0;
        w_ball_y_nxt = C_BY0;
        w_play_nxt   = 1'b0;
        w_state_nxt  = S_READY;
      end
      default: w_state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge pix_clk) begin
    if (rst_pix) begin
      r_state   <= S_READY;
      r_ball_x  <= C_BX0;
      r_ball_y  <= C_BY0;
      r_pad_l   <= C_PY0;
      r_pad_r   <= C_PY0;
      r_dx_left <= 1'b0;
      r_dy_up   <= 1'b0;
      r_play    <= 1'b0;
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ball_x  <= w_ball_x_nxt;
      r_ball_y  <= w_ball_y_nxt;
      r_pad_l   <= w_pad_l_nxt;
      r_pad_r   <= w_pad_r_nxt;
      r_dx_left <= w_dx_left_nxt;
      r_dy_up   <= w_dy_up_nxt;
      r_play    <= w_play_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
      r_tick    <= (sx == '0) && (sy == CORDW'(V_RES));
    end
  end

  assign ball_x     = r_ball_x[CORDW-1:0];
  assign ball_y     = r_ball_y[CORDW-1:0];
  assign pad_l_y    = r_pad_l[CORDW-1:0];
  assign pad_r_y    = r_pad_r[CORDW-1:0];
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign frame_tick = r_tick;
  assign busy       = (r_state == S_PADDLE) || (r_state == S_BALL) ||
                      (r_state == S_HIT) || (r_state == S_SCORE);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: frames are compressed to a blanking strobe plus a few cycles.
module tb_pong_game_ctrl;

  logic       pix_clk = 1'b0;
  logic       rst_pix;
  logic [9:0] sx, sy;
  logic       btn_up_l, btn_dn_l, btn_up_r, btn_dn_r, serve;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic       frame_tick, busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pix_clk = ~pix_clk;

  pong_game_ctrl dut (
    .pix_clk(pix_clk), .rst_pix(rst_pix), .sx(sx), .sy(sy),
    .btn_up_l(btn_up_l), .btn_dn_l(btn_dn_l), .btn_up_r(btn_up_r), .btn_dn_r(btn_dn_r),
    .serve(serve), .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .frame_tick(frame_tick), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, 32'(ball_x), x);
    chk({tag, "_y"}, 32'(ball_y), y);
  endtask

  task automatic chk_scores(input string tag, input int l, input int r);
    chk({tag, "_score_l"}, 32'(score_l), l);
    chk({tag, "_score_r"}, 32'(score_r), r);
  endtask

  // One compressed frame: blanking strobe, then six sampled cycles; returns busy-cycle count.
  task automatic frame(output int nb);
    nb = 0;
    @(posedge pix_clk); #1; sx = 10'd0; sy = 10'd480;
    @(posedge pix_clk); #1; sx = 10'd5;
    repeat (6) begin
      @(posedge pix_clk);
      @(negedge pix_clk);
      if (busy) nb++;
    end
  endtask

  task automatic frames(input int n);
    int nb;
    repeat (n) frame(nb);
  endtask

  task automatic serve_frame(output int nb);
    serve = 1'b1;
    frame(nb);
    serve = 1'b0;
  endtask

  initial begin
    int nb, ticks, bsum, tsx, tsy, sat;
    logic [9:0] psx, psy;
    rst_pix = 1'b1; sx = 10'd5; sy = 10'd0; serve = 1'b0;
    btn_up_l = 1'b0; btn_dn_l = 1'b0; btn_up_r = 1'b0; btn_dn_r = 1'b0;
    @(posedge pix_clk); #1; rst_pix = 1'b0;
    @(negedge pix_clk);
    chk_ball("rst", 316, 236);
    chk("rst_pad_l", 32'(pad_l_y), 216);
    chk("rst_pad_r", 32'(pad_r_y), 216);
    chk_scores("rst", 0, 0);
    chk("rst_tick", 32'(frame_tick), 0);
    chk("rst_busy", 32'(busy), 0);

    // Frame strobe across the lines around the start of blanking.
    ticks = 0; bsum = 0; tsx = -1; tsy = -1; psx = sx; psy = sy;
    for (int y = 478; y <= 482; y++) begin
      for (int x = 0; x < 800; x++) begin
        @(posedge pix_clk); #1;
        if (frame_tick) begin ticks++; tsx = int'(psx); tsy = int'(psy); end
        if (busy) bsum++;
        psx = 10'(x); psy = 10'(y); sx = psx; sy = psy;
      end
    end
    chk("strobe_count", 32'(ticks), 1);
    chk("strobe_sx", 32'(tsx), 0);
    chk("strobe_sy", 32'(tsy), 480);
    chk("strobe_busy_ready", 32'(bsum), 1);
    sx = 10'd5; sy = 10'd0;

    // Paddles while the ball waits in READY.
    btn_up_l = 1'b1; btn_dn_l = 1'b1;
    frame(nb); chk("pad_both", 32'(pad_l_y), 216);
    btn_dn_l = 1'b0;
    frames(53); chk("pad_up_53", 32'(pad_l_y), 4);
    frame(nb);  chk("pad_up_to0", 32'(pad_l_y), 0);
    frame(nb);  chk("pad_up_clamp", 32'(pad_l_y), 0);
    btn_up_l = 1'b0;
    chk("pad_r_idle", 32'(pad_r_y), 216);
    btn_dn_r = 1'b1;
    frames(53); chk("pad_dn_53", 32'(pad_r_y), 428);
    frame(nb);  chk("pad_dn_to432", 32'(pad_r_y), 432);
    frame(nb);  chk("pad_dn_clamp", 32'(pad_r_y), 432);
    btn_dn_r = 1'b0;
    chk_ball("ready_hold", 316, 236);

    // Round 1: bottom bounce, right paddle hit, top bounce, left miss.
    serve_frame(nb);
    chk("serve_busy", 32'(nb), 3);
    chk_ball("r1_n1", 318, 238);
    frames(117); chk_ball("r1_n118", 552, 472);
    frame(nb);   chk_ball("r1_n119", 554, 472);
    frame(nb);   chk_ball("r1_n120", 556, 470);
    frames(17);  chk_ball("r1_n137", 590, 436);
    frame(nb);   chk_ball("r1_hit_r", 592, 434);
    frame(nb);   chk_ball("r1_n139", 590, 432);
    frames(216); chk_ball("r1_n355", 158, 0);
    frame(nb);   chk_ball("r1_n356", 156, 0);
    frame(nb);   chk_ball("r1_n357", 154, 2);
    frames(76);  chk_ball("r1_n433", 2, 154);
    chk_scores("r1_pre", 0, 0);
    frame(nb);
    chk("miss_busy", 32'(nb), 4);
    chk_ball("r1_miss", 316, 236);
    chk_scores("r1_miss", 0, 1);
    frame(nb); chk_ball("r1_ready", 316, 236);

    // Centre both paddles, then a right miss and a left miss.
    btn_dn_l = 1'b1; btn_up_r = 1'b1;
    frames(54);
    chk("pad_l_mid", 32'(pad_l_y), 216);
    chk("pad_r_mid", 32'(pad_r_y), 216);
    btn_dn_l = 1'b0; btn_up_r = 1'b0;
    serve_frame(nb); frames(156); chk_ball("r2_n157", 630, 396);
    frame(nb); chk_ball("r2_miss", 316, 236); chk_scores("r2", 1, 1);
    serve_frame(nb); chk_ball("r3_n1", 314, 234);
    frames(156); chk_ball("r3_n157", 2, 76);
    frame(nb); chk_scores("r3", 1, 2);
    serve_frame(nb); frames(157); chk_scores("r4", 2, 2);

    // Left paddle hit: paddle at top, ball arrives travelling left after a top bounce.
    btn_up_l = 1'b1; frames(54); chk("pad_l_top", 32'(pad_l_y), 0); btn_up_l = 1'b0;
    serve_frame(nb); frames(136); chk_ball("r5_n137", 42, 36);
    frame(nb); chk_ball("r5_hit_l", 40, 38); chk_scores("r5", 2, 2);
    frame(nb); chk_ball("r5_n139", 42, 40);

    // Reset asserted while the FSM sits in BALL.
    @(posedge pix_clk); #1; sx = 10'd0; sy = 10'd480;
    @(posedge pix_clk); #1; sx = 10'd5;
    @(posedge pix_clk);
    @(posedge pix_clk); #1;
    chk("ball_state_busy", 32'(busy), 1);
    rst_pix = 1'b1;
    @(posedge pix_clk); #1; rst_pix = 1'b0;
    chk_ball("midrst", 316, 236);
    chk("midrst_pad_l", 32'(pad_l_y), 216);
    chk("midrst_pad_r", 32'(pad_r_y), 216);
    chk_scores("midrst", 0, 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tick", 32'(frame_tick), 0);
    frame(nb); chk_ball("midrst_ready", 316, 236);

    // Alternating misses until both scores saturate.
    for (int k = 1; k <= 10; k++) begin
      sat = (k > 9) ? 9 : k;
      serve_frame(nb); frames(157);
      chk("sat_score_l", 32'(score_l), sat);
      serve_frame(nb); frames(157);
      chk("sat_score_r", 32'(score_r), sat);
    end
    chk_ball("sat_centre", 316, 236);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
